// File: rtl/sn_cfg_loader.sv
// Boot-time configuration sequencer: replays a register image onto the prot_* bus,
// optionally verifying each write by readback, then passes the protocol manager through.
module sn_cfg_loader #(
    parameter int         P_IMG_DEPTH = 64,
    parameter int         P_IMG_AW    = $clog2(P_IMG_DEPTH),
    parameter logic [6:0] P_TERM_ADDR = 7'h7F,
    parameter bit         P_VERIFY_EN = 1'b1,
    parameter bit         P_AUTO_LOAD = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reload,
    output logic                img_rd,
    output logic [P_IMG_AW-1:0] img_addr,
    input  logic [14:0]         img_data,
    input  logic                up_prot_enable,
    input  logic                up_prot_r0w1,
    input  logic [6:0]          up_prot_addr,
    input  logic [7:0]          up_prot_wdata,
    output logic [7:0]          up_prot_rdata,
    output logic                prot_enable,
    output logic                prot_r0w1,
    output logic [6:0]          prot_addr,
    output logic [7:0]          prot_wdata,
    input  logic [7:0]          prot_rdata,
    output logic                load_busy,
    output logic                load_done,
    output logic [P_IMG_AW:0]   load_count,
    output logic                verify_err,
    output logic                drop_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [P_IMG_AW:0] LP_DEPTH = (P_IMG_AW + 1)'(P_IMG_DEPTH);
    localparam logic [P_IMG_AW:0] LP_ONE   = (P_IMG_AW + 1)'(1);

    state_t              state_q, state_d;
    logic [P_IMG_AW:0]   idx_q, idx_d;
    logic [6:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                load_done_q, load_done_d;
    logic                verify_err_q, verify_err_d;
    logic                drop_err_q, drop_err_d;
    logic                load_busy_q, load_busy_d;
    logic                img_rd_q, img_rd_d;
    logic [P_IMG_AW-1:0] img_addr_q, img_addr_d;
    logic                busy_s;
    logic [P_IMG_AW:0]   idx_inc_s;

    assign busy_s    = (state_q == S_FETCH) || (state_q == S_WRITE) || (state_q == S_CHECK);
    assign idx_inc_s = idx_q + LP_ONE;

    // Next-state, sticky flags and bus steering (pass-through vs. loader-owned).
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        data_d        = data_q;
        load_done_d   = load_done_q;
        verify_err_d  = verify_err_q;
        drop_err_d    = drop_err_q;
        prot_enable   = up_prot_enable;
        prot_r0w1     = up_prot_r0w1;
        prot_addr     = up_prot_addr;
        prot_wdata    = up_prot_wdata;
        up_prot_rdata = prot_rdata;

        if (busy_s) begin
            prot_enable   = 1'b0;
            prot_r0w1     = 1'b0;
            prot_addr     = 7'd0;
            prot_wdata    = 8'd0;
            up_prot_rdata = 8'd0;
            if (up_prot_enable) begin
                drop_err_d = 1'b1;
            end else begin
                drop_err_d = drop_err_q;
            end
        end else begin
            drop_err_d = drop_err_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_IDLE && P_AUTO_LOAD) || reload) begin
                    state_d      = S_FETCH;
                    idx_d        = '0;
                    load_done_d  = 1'b0;
                    verify_err_d = 1'b0;
                    drop_err_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (img_data[14:8] == P_TERM_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    prot_enable = 1'b1;
                    prot_r0w1   = 1'b1;
                    prot_addr   = img_data[14:8];
                    prot_wdata  = img_data[7:0];
                    addr_d      = img_data[14:8];
                    data_d      = img_data[7:0];
                    idx_d       = idx_inc_s;
                    if (P_VERIFY_EN) begin
                        state_d = S_CHECK;
                    end else if (idx_inc_s == LP_DEPTH) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_CHECK: begin
                prot_enable = 1'b1;
                prot_r0w1   = 1'b0;
                prot_addr   = addr_q;
                if (prot_rdata != data_q) begin
                    verify_err_d = 1'b1;
                end else begin
                    verify_err_d = verify_err_q;
                end
                // idx was already advanced in WRITE, so it equals the depth after the last entry.
                if (idx_q == LP_DEPTH) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            load_done_d = 1'b1;
        end else begin
            load_done_d = load_done_d;
        end

        // A load being reset must not leave any strobe on the network in that cycle.
        if (rst) begin
            prot_enable   = 1'b0;
            prot_r0w1     = 1'b0;
            prot_addr     = 7'd0;
            prot_wdata    = 8'd0;
            up_prot_rdata = 8'd0;
        end else begin
            up_prot_rdata = up_prot_rdata;
        end
    end

    // Status outputs are registered copies derived from the next state.
    always_comb begin
        load_busy_d = (state_d == S_FETCH) || (state_d == S_WRITE) || (state_d == S_CHECK);
        img_rd_d    = (state_d == S_FETCH);
        img_addr_d  = idx_d[P_IMG_AW-1:0];
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            addr_q       <= 7'd0;
            data_q       <= 8'd0;
            load_done_q  <= 1'b0;
            verify_err_q <= 1'b0;
            drop_err_q   <= 1'b0;
            load_busy_q  <= 1'b0;
            img_rd_q     <= 1'b0;
            img_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            load_done_q  <= load_done_d;
            verify_err_q <= verify_err_d;
            drop_err_q   <= drop_err_d;
            load_busy_q  <= load_busy_d;
            img_rd_q     <= img_rd_d;
            img_addr_q   <= img_addr_d;
        end
    end

    assign img_rd     = img_rd_q;
    assign img_addr   = img_addr_q;
    assign load_busy  = load_busy_q;
    assign load_done  = load_done_q;
    assign load_count = idx_q;
    assign verify_err = verify_err_q;
    assign drop_err   = drop_err_q;

endmodule
